// File: rtl/mips_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core: gates PC advance,
// services SYSCALL (halt or print $a0) and keeps execution statistics.
module mips_run_ctrl #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned HALT_CODE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_btn,
    input  logic             step_btn,
    input  logic             step_mode,
    input  logic             Syscall,
    input  logic             Jmp,
    input  logic             Branch_taken,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic [31:0]      disp_data,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] jmp_cnt,
    output logic [CNT_W-1:0] br_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               go_q, step_q;
    logic               running_q, running_d;
    logic               halted_q, halted_d;
    logic [DATA_W-1:0]  disp_q, disp_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   jmp_q, jmp_d;
    logic [CNT_W-1:0]   br_q, br_d;

    logic go_rise, step_rise, exec, is_halt_code, halt_sys;

    // Button edge detection and instruction-completion qualifiers
    assign go_rise      = go_btn & ~go_q;
    assign step_rise    = step_btn & ~step_q;
    assign exec         = (state_q == RUN) | ((state_q == STEP) & step_rise);
    assign is_halt_code = (v0 == DATA_W'(HALT_CODE));
    assign halt_sys     = exec & Syscall & is_halt_code;

    // PC holds on the halting syscall so it still points at it while halted
    assign pc_en = exec & ~halt_sys;

    assign running   = running_q;
    assign halted    = halted_q;
    assign disp_data = disp_q;
    assign cycle_cnt = cyc_q;
    assign jmp_cnt   = jmp_q;
    assign br_cnt    = br_q;

    // State register, button history and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            go_q      <= 1'b1;
            step_q    <= 1'b1;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            disp_q    <= '0;
            cyc_q     <= '0;
            jmp_q     <= '0;
            br_q      <= '0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_btn;
            step_q    <= step_btn;
            running_q <= running_d;
            halted_q  <= halted_d;
            disp_q    <= disp_d;
            cyc_q     <= cyc_d;
            jmp_q     <= jmp_d;
            br_q      <= br_d;
        end
    end

    // Next-state, status decode, display latch and saturating counters
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        cyc_d   = cyc_q;
        jmp_d   = jmp_q;
        br_d    = br_q;

        unique case (state_q)
            IDLE: begin
                if (go_rise) begin
                    state_d = step_mode ? STEP : RUN;
                end
            end
            RUN: begin
                if (halt_sys) begin
                    state_d = HALT;
                end else if (step_mode) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (halt_sys) begin
                    state_d = HALT;
                end else if (!step_mode) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (exec) begin
            if (Syscall && !is_halt_code) begin
                disp_d = a0;
            end
            if (cyc_q != CNT_MAX) begin
                cyc_d = cyc_q + CNT_W'(1);
            end
            if (Jmp && (jmp_q != CNT_MAX)) begin
                jmp_d = jmp_q + CNT_W'(1);
            end
            if (Branch_taken && (br_q != CNT_MAX)) begin
                br_d = br_q + CNT_W'(1);
            end
        end

        running_d = (state_d == RUN) || (state_d == STEP);
        halted_d  = (state_d == HALT);
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: a behavioural model pushes expected
// post-edge outputs into a scoreboard that is popped after each clock edge.
module tb_mips_run_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STEP = 2;
    localparam int S_HALT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go_btn, step_btn, step_mode, Syscall, Jmp, Branch_taken;
    logic [31:0] v0, a0;

    logic        pc_en, running, halted;
    logic [31:0] disp_data, cycle_cnt, jmp_cnt, br_cnt;

    logic        s_pc_en, s_running, s_halted;
    logic [31:0] s_disp;
    logic [3:0]  s_cyc, s_jmp, s_br;

    mips_run_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .go_btn(go_btn), .step_btn(step_btn),
        .step_mode(step_mode), .Syscall(Syscall), .Jmp(Jmp),
        .Branch_taken(Branch_taken), .v0(v0), .a0(a0),
        .pc_en(pc_en), .running(running), .halted(halted),
        .disp_data(disp_data), .cycle_cnt(cycle_cnt), .jmp_cnt(jmp_cnt),
        .br_cnt(br_cnt)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation
    mips_run_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .go_btn(go_btn), .step_btn(step_btn),
        .step_mode(step_mode), .Syscall(Syscall), .Jmp(Jmp),
        .Branch_taken(Branch_taken), .v0(v0), .a0(a0),
        .pc_en(s_pc_en), .running(s_running), .halted(s_halted),
        .disp_data(s_disp), .cycle_cnt(s_cyc), .jmp_cnt(s_jmp),
        .br_cnt(s_br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cyc, jmp, br, disp;
        logic        run, hlt;
        logic [3:0]  scyc, sjmp, sbr;
    } exp_t;

    exp_t sb[$];

    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_state;
    logic        m_go_q, m_step_q;
    int unsigned m_cyc, m_jmp, m_br;
    logic [31:0] m_disp;

    function automatic logic [3:0] sat4(input int unsigned v);
        return (v > 15) ? 4'd15 : v[3:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = S_IDLE;
        m_go_q   = 1'b1;
        m_step_q = 1'b1;
        m_cyc    = 0;
        m_jmp    = 0;
        m_br     = 0;
        m_disp   = '0;
    endtask

    task automatic check_post(input exp_t e);
        chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
        chk("jmp_cnt",   64'(jmp_cnt),   64'(e.jmp));
        chk("br_cnt",    64'(br_cnt),    64'(e.br));
        chk("disp_data", 64'(disp_data), 64'(e.disp));
        chk("running",   64'(running),   64'(e.run));
        chk("halted",    64'(halted),    64'(e.hlt));
        chk("sat_cycle", 64'(s_cyc),     64'(e.scyc));
        chk("sat_jmp",   64'(s_jmp),     64'(e.sjmp));
        chk("sat_br",    64'(s_br),      64'(e.sbr));
    endtask

    // One clock of stimulus: drive, check pc_en, push expectation, clock, pop and compare
    task automatic step(input logic go, input logic stp, input logic mode,
                        input logic sys, input logic j, input logic b,
                        input logic [31:0] v0v, input logic [31:0] a0v);
        logic go_rise, step_rise, ex, hs;
        exp_t e;
        go_btn = go; step_btn = stp; step_mode = mode;
        Syscall = sys; Jmp = j; Branch_taken = b; v0 = v0v; a0 = a0v;

        go_rise   = go & ~m_go_q;
        step_rise = stp & ~m_step_q;
        ex = (m_state == S_RUN) || ((m_state == S_STEP) && step_rise);
        hs = ex && sys && (v0v == 32'd10);

        #3;
        chk("pc_en", 64'(pc_en), 64'(ex && !hs));

        case (m_state)
            S_IDLE: if (go_rise) m_state = mode ? S_STEP : S_RUN;
            S_RUN:  if (hs) m_state = S_HALT; else if (mode) m_state = S_STEP;
            S_STEP: if (hs) m_state = S_HALT; else if (!mode) m_state = S_RUN;
            default: m_state = S_HALT;
        endcase
        if (ex) begin
            m_cyc = m_cyc + 1;
            if (j) m_jmp = m_jmp + 1;
            if (b) m_br = m_br + 1;
            if (sys && v0v != 32'd10) m_disp = a0v;
        end
        m_go_q   = go;
        m_step_q = stp;

        e.cyc  = m_cyc;
        e.jmp  = m_jmp;
        e.br   = m_br;
        e.disp = m_disp;
        e.run  = (m_state == S_RUN) || (m_state == S_STEP);
        e.hlt  = (m_state == S_HALT);
        e.scyc = sat4(m_cyc);
        e.sjmp = sat4(m_jmp);
        e.sbr  = sat4(m_br);
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_post(e);
        end
    endtask

    // Immediate async reset checks; caller is just after a rising edge
    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_pc_en"},   64'(pc_en),     64'd0);
        chk({tag, "_cycle"},   64'(cycle_cnt), 64'd0);
        chk({tag, "_jmp"},     64'(jmp_cnt),   64'd0);
        chk({tag, "_br"},      64'(br_cnt),    64'd0);
        chk({tag, "_disp"},    64'(disp_data), 64'd0);
        chk({tag, "_running"}, 64'(running),   64'd0);
        chk({tag, "_halted"},  64'(halted),    64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        go_btn = 1'b0; step_btn = 1'b0; step_mode = 1'b0;
        Syscall = 1'b0; Jmp = 1'b0; Branch_taken = 1'b0;
        v0 = '0; a0 = '0;
        model_reset();

        #12;
        async_reset_check("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Free run: release, press go, 20 NOPs (narrow copy saturates at 15)
        step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step((i < 3) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        end

        // Print syscall keeps running
        step(0, 0, 0, 1, 0, 0, 32'd1, 32'h0000_1234);
        step(0, 0, 0, 0, 0, 0, 32'd1, 32'hdead_beef);

        // Jumps and taken branches while running
        step(0, 0, 0, 0, 1, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'd0, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
        step(0, 0, 0, 0, 1, 0, 32'd0, 32'd0);

        // Into single-step; decoder strobes without exec are ignored
        step(0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 1, 1, 1, 1, 32'd1, 32'h5555_aaaa);
        step(0, 0, 1, 0, 1, 1, 32'd0, 32'd0);

        // Step held five cycles gives one instruction; re-press gives one more
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        step(0, 1, 1, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 1, 0, 0, 0, 32'd0, 32'd0);

        // Step edge with step_mode cleared executes and returns to RUN
        step(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Halting syscall while switching to step mode: HALT wins, counted once
        step(0, 0, 1, 1, 0, 0, 32'd10, 32'h0000_0bad);
        for (int i = 0; i < 6; i++) begin
            step(i[0], i[1], i[2], 1, 1, 1, 32'd1, 32'h7777_7777);
        end

        // Go held through reset release stays idle
        go_btn = 1'b1;
        async_reset_check("reset_halt");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Start in step mode via go, then run and reset mid-run
        step(0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        step(1, 0, 1, 0, 0, 0, 32'd0, 32'd0);
        step(0, 1, 0, 0, 1, 0, 32'd0, 32'd0);
        step(0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
        step(0, 0, 0, 1, 0, 0, 32'd3, 32'hcafe_f00d);
        async_reset_check("reset_run");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
